debounced_counter: RTL and testbench

//   Parametrised up/down counter driven by raw, bouncy active-low pushbuttons.

---
 rtl/debounced_counter_pkg.sv | 17 +
 rtl/button_debouncer.sv | 59 +++++
 rtl/debounced_counter.sv | 100 ++++++++++
 tb/tb_debounced_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/debounced_counter_pkg.sv
// Shared helpers for the debounced button counter: stability counter sizing
// and the encoding of the per-cycle count update decision.
package debounced_counter_pkg;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_CLR,
    UPD_UP,
    UPD_DN
  } upd_e;

  // Stability counter must be able to hold DEBOUNCE_CYCLES-1 (and never be 0 bits wide).
  function automatic int stab_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces one raw active-low button; emits a one-cycle
// press_pulse on each accepted released->pressed transition.
module button_debouncer
  import debounced_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int            CW   = stab_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Any cycle where the synchronised input agrees with the accepted state restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (btn_s != state_q) begin
      if (cnt_q == LAST) begin
        state_d = btn_s;
        pulse_d = ~btn_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign pressed     = ~state_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/debounced_counter.sv
// Up/down/clear counter driven by three debounced active-low pushbuttons;
// each accepted press yields exactly one count update and one evt pulse.
module debounced_counter
  import debounced_counter_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SYNC_STAGES     = 2,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up_n,
  input  logic             btn_dn_n,
  input  logic             btn_clr_n,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             evt
);

  if (WIDTH < 1) begin : g_bad_width
    $error("debounced_counter: WIDTH must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("debounced_counter: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounced_counter: SYNC_STAGES must be >= 2");
  end

  localparam logic [WIDTH-1:0] MAX = '1;

  logic up_pressed, dn_pressed, clr_pressed;
  logic up_pulse, dn_pulse, clr_pulse;
  logic up_stb, dn_stb, clr_stb;

  logic [WIDTH-1:0] count_q, count_d;
  logic             evt_q, evt_d;
  upd_e             upd;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_up (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_up_n), .pressed(up_pressed), .press_pulse(up_pulse)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_dn (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_dn_n), .pressed(dn_pressed), .press_pulse(dn_pulse)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_clr_n), .pressed(clr_pressed), .press_pulse(clr_pulse)
  );

  // A pulse is only issued together with the pressed state, so this qualifier never drops one.
  assign up_stb  = up_pulse  & up_pressed;
  assign dn_stb  = dn_pulse  & dn_pressed;
  assign clr_stb = clr_pulse & clr_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      evt_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
    end
  end

  always_comb begin
    upd = UPD_NONE;
    if (clr_stb)               upd = UPD_CLR;
    else if (up_stb && dn_stb) upd = UPD_NONE;
    else if (up_stb)           upd = UPD_UP;
    else if (dn_stb)           upd = UPD_DN;
  end

  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    case (upd)
      UPD_CLR: begin
        count_d = '0;
        evt_d   = 1'b1;
      end
      UPD_UP: begin
        evt_d = 1'b1;
        if (!(SATURATE != 0 && count_q == MAX)) count_d = count_q + WIDTH'(1);
      end
      UPD_DN: begin
        evt_d = 1'b1;
        if (!(SATURATE != 0 && count_q == '0)) count_d = count_q - WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign count  = count_q;
  assign evt    = evt_q;
  assign at_max = (count_q == MAX);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_debounced_counter.sv
// Directed bench for debounced_counter: a wrapping and a saturating instance
// share the same buttons and are checked against hand-computed values.
module tb_debounced_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_n = 1'b1, dn_n = 1'b1, clr_n = 1'b1;
  logic [3:0] cnt_w, cnt_s;
  logic       max_w, min_w, evt_w, max_s, min_s, evt_s;

  int checks = 0;
  int failures = 0;
  int evt_cnt_w = 0;
  int evt_cnt_s = 0;
  int base_w, base_s;

  always #5 clk = ~clk;

  debounced_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .btn_up_n(up_n), .btn_dn_n(dn_n), .btn_clr_n(clr_n),
    .count(cnt_w), .at_max(max_w), .at_min(min_w), .evt(evt_w)
  );

  debounced_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .btn_up_n(up_n), .btn_dn_n(dn_n), .btn_clr_n(clr_n),
    .count(cnt_s), .at_max(max_s), .at_min(min_s), .evt(evt_s)
  );

  always @(negedge clk) begin
    if (evt_w) evt_cnt_w++;
    if (evt_s) evt_cnt_s++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: up_n = v;
      1: dn_n = v;
      default: clr_n = v;
    endcase
  endtask

  // Hold 10 cycles (strobe lands at 7), then release long enough to debounce.
  task automatic press(input int b);
    set_btn(b, 1'b0);
    tick(10);
    set_btn(b, 1'b1);
    tick(10);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_count", cnt_w, 0);
    chk("rst_evt", evt_w, 0);
    chk("rst_at_min", min_w, 1);
    chk("rst_at_max", max_w, 0);
    chk("rst_sat_count", cnt_s, 0);
    rst_n = 1'b1;
    tick(2);

    // 1. Clean up press: update exactly 7 cycles after the raw edge
    up_n = 1'b0;
    tick(6);
    chk("t1_evt_c6", evt_w, 0);
    chk("t1_count_c6", cnt_w, 0);
    tick(1);
    chk("t1_evt_c7", evt_w, 1);
    chk("t1_count_c7", cnt_w, 1);
    tick(1);
    chk("t1_evt_c8", evt_w, 0);
    tick(2);
    up_n = 1'b1;
    tick(10);
    chk("t1_evt_total", evt_cnt_w, 1);
    chk("t1_at_min", min_w, 0);

    // 2. Bounce every cycle, then settle low
    base_w = evt_cnt_w;
    for (int i = 0; i < 20; i++) begin
      up_n = (i % 2 == 1);
      tick(1);
    end
    tick(6);
    chk("t2_no_evt_bounce", evt_cnt_w, base_w);
    chk("t2_count_bounce", cnt_w, 1);
    up_n = 1'b0;
    tick(10);
    up_n = 1'b1;
    tick(10);
    chk("t2_count", cnt_w, 2);
    chk("t2_evt_total", evt_cnt_w, base_w + 1);

    // 3. Up to the top, then one more
    for (int i = 0; i < 13; i++) press(0);
    chk("t3_count_15", cnt_w, 15);
    chk("t3_at_max", max_w, 1);
    chk("t3_sat_count_15", cnt_s, 15);
    base_s = evt_cnt_s;
    press(0);
    chk("t3_wrap_count", cnt_w, 0);
    chk("t3_wrap_at_min", min_w, 1);
    chk("t3_sat_hold", cnt_s, 15);
    chk("t3_sat_at_max", max_s, 1);
    chk("t3_sat_evt", evt_cnt_s, base_s + 1);

    // 4. Clear both, then dn from 0
    base_w = evt_cnt_w;
    press(2);
    chk("t4_clr_at_zero_evt", evt_cnt_w, base_w + 1);
    chk("t4_sat_clr", cnt_s, 0);
    press(1);
    chk("t4_dn_wrap", cnt_w, 15);
    chk("t4_dn_sat", cnt_s, 0);
    chk("t4_sat_at_min", min_s, 1);

    // 5. Aligned up+dn cancels; aligned clr+up clears
    base_w = evt_cnt_w;
    up_n = 1'b0;
    dn_n = 1'b0;
    tick(10);
    up_n = 1'b1;
    dn_n = 1'b1;
    tick(10);
    chk("t5_updn_count", cnt_w, 15);
    chk("t5_updn_no_evt", evt_cnt_w, base_w);
    for (int i = 0; i < 6; i++) press(1);
    chk("t5_count_9", cnt_w, 9);
    base_w = evt_cnt_w;
    up_n = 1'b0;
    clr_n = 1'b0;
    tick(7);
    chk("t5_clrup_evt", evt_w, 1);
    chk("t5_clrup_count", cnt_w, 0);
    tick(3);
    up_n = 1'b1;
    clr_n = 1'b1;
    tick(10);
    chk("t5_clrup_evt_total", evt_cnt_w, base_w + 1);

    // 6. Reset mid-debounce, button held across release
    press(0);
    chk("t6_count_1", cnt_w, 1);
    base_w = evt_cnt_w;
    up_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", cnt_w, 0);
    chk("t6_async_evt", evt_w, 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("t6_count_c6", cnt_w, 0);
    chk("t6_evt_c6", evt_cnt_w, base_w);
    tick(1);
    chk("t6_count_c7", cnt_w, 1);
    chk("t6_evt_c7", evt_w, 1);
    chk("t6_sat_count_c7", cnt_s, 1);
    up_n = 1'b1;
    tick(10);
    chk("t6_evt_total", evt_cnt_w, base_w + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
